// File: rtl/vmicro16_mmu_pkg.sv
// vmicro16_mmu_pkg
//   Shared definitions for the vmicro16 data-memory unit. The core and the SoC
//   decode addresses with the same constants, so region and state encodings
//   live here rather than inside the MMU.
//   Contents:
//     mmu_state_t            FSM state encoding (IDLE, RAM, PERI, RESP)
//     VMICRO16_MMU_PERI_BIT  address bit that selects the peripheral region
//     mmu_cnt_width()        width of the peripheral wait counter

package vmicro16_mmu_pkg;

    typedef enum logic [1:0] {
        MMU_IDLE = 2'd0,
        MMU_RAM  = 2'd1,
        MMU_PERI = 2'd2,
        MMU_RESP = 2'd3
    } mmu_state_t;

    // Any address with this bit set belongs to the peripheral bus.
    localparam int VMICRO16_MMU_PERI_BIT = 15;

    // Counter must hold 0..timeout; keep at least one bit so that a timeout of
    // zero (wait forever) still yields a legal vector.
    function automatic int mmu_cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/vmicro16_mmu_if.sv
// vmicro16_mmu_if
//   Bundles the core-facing request/response signals and the peripheral
//   access port of the MMU.
//   Signals:
//     core_req/core_we/core_addr/core_wdata   request from the core ME stage
//     core_rdata/core_ack/core_err/busy       response to the core
//     p_sel/p_we/p_addr/p_wdata               peripheral access from the MMU
//     p_rdata/p_ready                         peripheral response
//   Modports:
//     slave   the MMU's view (serves the core, drives the peripheral port)
//     master  the environment's view (core plus peripheral)

interface vmicro16_mmu_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int PERI_AW    = 8
);

    logic                  core_req;
    logic                  core_we;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic [DATA_WIDTH-1:0] core_rdata;
    logic                  core_ack;
    logic                  core_err;
    logic                  busy;

    logic                  p_sel;
    logic                  p_we;
    logic [PERI_AW-1:0]    p_addr;
    logic [DATA_WIDTH-1:0] p_wdata;
    logic [DATA_WIDTH-1:0] p_rdata;
    logic                  p_ready;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, p_rdata, p_ready,
        output core_rdata, core_ack, core_err, busy,
               p_sel, p_we, p_addr, p_wdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, p_rdata, p_ready,
        input  core_rdata, core_ack, core_err, busy,
               p_sel, p_we, p_addr, p_wdata
    );

endinterface

// File: rtl/vmicro16_mmu_bram.sv
// vmicro16_mmu_bram
//   Simple dual-port scratch RAM: one synchronous write port and one
//   synchronous (registered) read port. Contents are never cleared.
//   Ports:
//     clk        clock
//     mem_we     write enable
//     mem_waddr  write word address
//     mem_wdata  write data
//     mem_raddr  read word address
//     mem_rdata  read data, valid the cycle after mem_raddr is presented

module vmicro16_mmu_bram #(
    parameter int MEM_WIDTH = 16,
    parameter int MEM_DEPTH = 64,
    parameter int AW        = 6
) (
    input  logic                 clk,
    input  logic                 mem_we,
    input  logic [AW-1:0]        mem_waddr,
    input  logic [MEM_WIDTH-1:0] mem_wdata,
    input  logic [AW-1:0]        mem_raddr,
    output logic [MEM_WIDTH-1:0] mem_rdata
);

    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_raddr];
    end

endmodule

// File: rtl/vmicro16_mmu.sv
// vmicro16_mmu
//   Data-memory unit for the vmicro16 core ME stage. Takes one LW/SW request
//   at a time, decodes the address and serves it from scratch BRAM or the
//   peripheral port, then answers with a one-cycle ack (and err).
//   Ports:
//     clk    clock, all flops on posedge
//     reset  asynchronous, active-low reset
//     bus    vmicro16_mmu_if.slave: core request/response + peripheral port
//   Address map: addr[15]=1 -> peripheral (p_addr = addr[PERI_AW-1:0]);
//   addr < MEM_DEPTH -> scratch RAM; anything else completes with err=1.

module vmicro16_mmu
    import vmicro16_mmu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_DEPTH  = 64,
    parameter int PERI_AW    = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic          clk,
    input  logic          reset,
    vmicro16_mmu_if.slave bus
);

    localparam int RAM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int LAT_AW = (PERI_AW > RAM_AW) ? PERI_AW : RAM_AW;
    localparam int CNT_W  = mmu_cnt_width(TIMEOUT);
    localparam logic [ADDR_WIDTH-1:0] RAM_LIMIT = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    mmu_state_t            state_reg, state_next;
    logic                  lat_we_reg;
    logic [LAT_AW-1:0]     lat_addr_reg;
    logic [DATA_WIDTH-1:0] lat_wdata_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  ram_phase_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  err_reg;

    logic                  peri_hit, ram_hit, timeout_hit, bram_we;
    logic [DATA_WIDTH-1:0] bram_rdata;

    always_comb begin
        peri_hit    = bus.core_addr[VMICRO16_MMU_PERI_BIT];
        ram_hit     = !peri_hit && (bus.core_addr < RAM_LIMIT);
        // The last allowed wait cycle is the one where the counter reads
        // TIMEOUT-1, giving exactly TIMEOUT cycles with p_sel high.
        timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);
        // Stores go straight from the request inputs on the accepting edge.
        bram_we     = (state_reg == MMU_IDLE) && bus.core_req && ram_hit && bus.core_we;
    end

    // Reads use the latched address, so data is registered out of the RAM at
    // the end of the first RAM cycle and captured at the end of the second.
    vmicro16_mmu_bram #(
        .MEM_WIDTH (DATA_WIDTH),
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (RAM_AW)
    ) u_bram (
        .clk       (clk),
        .mem_we    (bram_we),
        .mem_waddr (bus.core_addr[RAM_AW-1:0]),
        .mem_wdata (bus.core_wdata),
        .mem_raddr (lat_addr_reg[RAM_AW-1:0]),
        .mem_rdata (bram_rdata)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= MMU_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MMU_IDLE: begin
                if (bus.core_req) begin
                    if (ram_hit)       state_next = MMU_RAM;
                    else if (peri_hit) state_next = MMU_PERI;
                    else               state_next = MMU_RESP;
                end
            end
            MMU_RAM:  if (ram_phase_reg) state_next = MMU_RESP;
            MMU_PERI: if (bus.p_ready || timeout_hit) state_next = MMU_RESP;
            MMU_RESP: state_next = MMU_IDLE;
            default:  state_next = MMU_IDLE;
        endcase
    end

    // Request latch, wait counter and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_we_reg    <= 1'b0;
            lat_addr_reg  <= '0;
            lat_wdata_reg <= '0;
            cnt_reg       <= '0;
            ram_phase_reg <= 1'b0;
            rdata_reg     <= '0;
            err_reg       <= 1'b0;
        end else begin
            case (state_reg)
                MMU_IDLE: begin
                    if (bus.core_req) begin
                        lat_we_reg    <= bus.core_we;
                        lat_addr_reg  <= bus.core_addr[LAT_AW-1:0];
                        lat_wdata_reg <= bus.core_wdata;
                        cnt_reg       <= '0;
                        ram_phase_reg <= 1'b0;
                        rdata_reg     <= '0;
                        err_reg       <= !(ram_hit || peri_hit);
                    end
                end
                MMU_RAM: begin
                    ram_phase_reg <= 1'b1;
                    if (ram_phase_reg && !lat_we_reg) begin
                        rdata_reg <= bram_rdata;
                    end
                end
                MMU_PERI: begin
                    // p_ready takes priority over a timeout in the same cycle.
                    if (bus.p_ready) begin
                        err_reg <= 1'b0;
                        if (!lat_we_reg) rdata_reg <= bus.p_rdata;
                    end else begin
                        if (cnt_reg != '1) cnt_reg <= cnt_reg + 1'b1;
                        if (timeout_hit)   err_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state so that reset removes them at once.
    always_comb begin
        bus.core_ack   = (state_reg == MMU_RESP);
        bus.busy       = (state_reg != MMU_IDLE);
        bus.p_sel      = (state_reg == MMU_PERI);
        bus.p_we       = 1'b0;
        bus.p_addr     = '0;
        bus.p_wdata    = '0;
        bus.core_rdata = rdata_reg;
        bus.core_err   = err_reg;
        if (state_reg == MMU_PERI) begin
            bus.p_we    = lat_we_reg;
            bus.p_addr  = lat_addr_reg[PERI_AW-1:0];
            bus.p_wdata = lat_wdata_reg;
        end
    end

endmodule
